alarm_ctrl: RTL and testbench

- Sequential alarm-clock controller: keeps day-of-week/hour/minute time, holds one programmable alarm time, and runs the ring/snooze/stop state machine.
- Sits between the minute-tick source and the user buttons on one side and the alarm sounder on the other.
- The weekday-enable rule is the existing alarm-day decode: alarm armed on day codes 0, 2 and 4 only.

---
 rtl/alarm_ctrl.sv | 158 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: day/hour/minute timekeeping, one programmable alarm,
// and the IDLE/RING/SNOOZE sounder state machine. All outputs are registered.
module alarm_ctrl #(
    parameter int SNOOZE_MIN   = 9,
    parameter int RING_MAX_MIN = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_min,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [2:0] day_in,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic       alrm,
    output logic [2:0] day,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);
    localparam logic [5:0] RING_LIMIT  = 6'(RING_MAX_MIN);

    state_t     state_q, state_d;
    logic       alrm_q, alrm_d;
    logic [2:0] day_q, day_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [4:0] alarm_hour_q, alarm_hour_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic [5:0] ring_cnt_q, ring_cnt_d;
    logic [5:0] snooze_cnt_q, snooze_cnt_d;

    logic time_ok, alarm_ok, load_time, tick, match;

    // Armed weekdays are codes 0, 2 and 4.
    function automatic logic day_ok(input logic [2:0] d);
        return !d[0] & (!d[2] | !d[1]);
    endfunction

    assign alarm_ok  = (hour_in <= 5'd23) && (min_in <= 6'd59);
    assign time_ok   = alarm_ok && (day_in <= 3'd6);
    assign load_time = set_time & time_ok;
    assign tick      = tick_min & ~load_time;

    always_comb begin
        day_d        = day_q;
        hour_d       = hour_q;
        min_d        = min_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        match        = 1'b0;

        if (load_time) begin
            day_d  = day_in;
            hour_d = hour_in;
            min_d  = min_in;
        end else if (tick) begin
            if (min_q == 6'd59) begin
                min_d = 6'd0;
                if (hour_q == 5'd23) begin
                    hour_d = 5'd0;
                    day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
                end else begin
                    hour_d = hour_q + 5'd1;
                end
            end else begin
                min_d = min_q + 6'd1;
            end
        end

        if (set_alarm && alarm_ok) begin
            alarm_hour_d = hour_in;
            alarm_min_d  = min_in;
        end

        // A trigger is judged on the post-tick time against the alarm held before this edge.
        match = tick && (hour_d == alarm_hour_q) && (min_d == alarm_min_q) && day_ok(day_d);

        if (!alarm_en || stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!snooze && match) begin
                        state_d    = RING;
                        ring_cnt_d = 6'd0;
                    end
                end
                RING: begin
                    if (snooze) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = SNOOZE_LOAD;
                    end else if (tick) begin
                        ring_cnt_d = (ring_cnt_q == 6'd63) ? ring_cnt_q : ring_cnt_q + 6'd1;
                        if (ring_cnt_d == RING_LIMIT) state_d = IDLE;
                    end
                end
                SNOOZE: begin
                    if (tick) begin
                        snooze_cnt_d = (snooze_cnt_q == 6'd0) ? 6'd0 : snooze_cnt_q - 6'd1;
                        if (snooze_cnt_d == 6'd0) begin
                            state_d    = RING;
                            ring_cnt_d = 6'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        alrm_d = (state_d == RING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alrm_q       <= 1'b0;
            day_q        <= 3'd0;
            hour_q       <= 5'd0;
            min_q        <= 6'd0;
            alarm_hour_q <= 5'd0;
            alarm_min_q  <= 6'd0;
            ring_cnt_q   <= 6'd0;
            snooze_cnt_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            alrm_q       <= alrm_d;
            day_q        <= day_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    assign alrm   = alrm_q;
    assign day    = day_q;
    assign hour   = hour_q;
    assign minute = min_q;
    assign state  = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus random stimulus,
// compared against a minutes-of-week reference model.
module tb_alarm_ctrl;

    localparam int SNOOZE_MIN   = 9;
    localparam int RING_MAX_MIN = 30;
    localparam int WEEK_MIN     = 7 * 1440;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_min, set_time, set_alarm, alarm_en, snooze, stop;
    logic [2:0] day_in;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic       alrm;
    logic [2:0] day;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [1:0] state;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: time as minutes since day 0 00:00, alarm as minute of day.
    int mWeek, mAlarm, mState, mRung, mSnoozeLeft;

    alarm_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_MAX_MIN(RING_MAX_MIN)) dut (
        .clk(clk), .rst_n(rst_n), .tick_min(tick_min), .set_time(set_time),
        .set_alarm(set_alarm), .day_in(day_in), .hour_in(hour_in), .min_in(min_in),
        .alarm_en(alarm_en), .snooze(snooze), .stop(stop), .alrm(alrm),
        .day(day), .hour(hour), .minute(minute), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".day"}, int'(day), mWeek / 1440);
        checkOutput({tag, ".hour"}, int'(hour), (mWeek % 1440) / 60);
        checkOutput({tag, ".minute"}, int'(minute), mWeek % 60);
        checkOutput({tag, ".state"}, int'(state), mState);
        checkOutput({tag, ".alrm"}, int'(alrm), (mState == 1) ? 1 : 0);
    endtask

    task automatic modelReset();
        mWeek = 0; mAlarm = 0; mState = 0; mRung = 0; mSnoozeLeft = 0;
    endtask

    task automatic modelStep(input int tk, input int st, input int sa, input int d,
                             input int h, input int m, input int en, input int sz, input int sp);
        bit validTime, effTick, hit;
        int oldAlarm, nd;
        validTime = (st != 0) && d <= 6 && h <= 23 && m <= 59;
        effTick   = (tk != 0) && !validTime;
        oldAlarm  = mAlarm;
        if (validTime) mWeek = d * 1440 + h * 60 + m;
        else if (effTick) mWeek = (mWeek + 1) % WEEK_MIN;
        if (sa != 0 && h <= 23 && m <= 59) mAlarm = h * 60 + m;
        nd  = mWeek / 1440;
        hit = effTick && (mWeek % 1440 == oldAlarm) && (nd == 0 || nd == 2 || nd == 4);
        if (en == 0 || sp != 0) mState = 0;
        else if (mState == 0) begin
            if (sz == 0 && hit) begin mState = 1; mRung = 0; end
        end else if (mState == 1) begin
            if (sz != 0) begin mState = 2; mSnoozeLeft = SNOOZE_MIN; end
            else if (effTick) begin
                mRung++;
                if (mRung >= RING_MAX_MIN) mState = 0;
            end
        end else begin
            if (effTick) begin
                mSnoozeLeft--;
                if (mSnoozeLeft <= 0) begin mState = 1; mRung = 0; end
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input int tk, input int st, input int sa,
                                 input int d, input int h, input int m, input int en,
                                 input int sz, input int sp);
        tick_min  = (tk != 0);
        set_time  = (st != 0);
        set_alarm = (sa != 0);
        day_in    = 3'(d);
        hour_in   = 5'(h);
        min_in    = 6'(m);
        alarm_en  = (en != 0);
        snooze    = (sz != 0);
        stop      = (sp != 0);
        @(posedge clk);
        modelStep(tk, st, sa, d, h, m, en, sz, sp);
        #1;
        checkAll(tag);
        tick_min = 0; set_time = 0; set_alarm = 0; snooze = 0; stop = 0;
    endtask

    task automatic doTick(input string tag);
        applyStimulus(tag, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic loadTime(input string tag, input int d, input int h, input int m);
        applyStimulus(tag, 0, 1, 0, d, h, m, 1, 0, 0);
    endtask

    initial begin
        int tk, st, sa, d, h, m, sz, sp, en, nt;
        rst_n = 0; tick_min = 0; set_time = 0; set_alarm = 0; alarm_en = 1;
        snooze = 0; stop = 0; day_in = 0; hour_in = 0; min_in = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1;

        // Day and week rollover.
        loadTime("set_d2", 2, 23, 59);
        doTick("wrap_d2");
        checkOutput("wrap_d2_day", int'(day), 3);
        loadTime("set_d6", 6, 23, 59);
        doTick("wrap_d6");
        checkOutput("wrap_d6_day", int'(day), 0);

        // Trigger on day 0, snooze for exactly SNOOZE_MIN ticks, then ring out.
        applyStimulus("alarm0700", 0, 0, 1, 0, 7, 0, 1, 0, 0);
        loadTime("set_0659", 0, 6, 59);
        doTick("trigger");
        checkOutput("trigger_alrm", int'(alrm), 1);
        applyStimulus("snooze", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < SNOOZE_MIN - 1; i++) doTick("snoozing");
        checkOutput("snooze_hold", int'(state), 2);
        doTick("snooze_end");
        checkOutput("snooze_end_state", int'(state), 1);
        for (int i = 0; i < RING_MAX_MIN - 1; i++) doTick("ringing");
        checkOutput("ring_hold", int'(state), 1);
        doTick("ring_timeout");
        checkOutput("ring_timeout_state", int'(state), 0);

        // Stop beats snooze in the same cycle.
        loadTime("set_0659b", 0, 6, 59);
        doTick("trigger_b");
        applyStimulus("stop_snooze", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("stop_snooze_state", int'(state), 0);

        // Disarmed days.
        loadTime("set_d1", 1, 6, 59);
        doTick("no_ring_d1");
        loadTime("set_d6b", 6, 6, 59);
        doTick("no_ring_d6");
        checkOutput("no_ring_d6_alrm", int'(alrm), 0);

        // Loading onto the alarm time, invalid load, tick dropped by load.
        loadTime("load_match", 4, 7, 0);
        checkOutput("load_match_state", int'(state), 0);
        applyStimulus("bad_hour", 0, 1, 0, 3, 24, 5, 1, 0, 0);
        applyStimulus("tick_and_load", 1, 1, 0, 2, 10, 10, 1, 0, 0);
        checkOutput("tick_and_load_min", int'(minute), 10);

        // Dropping alarm_en in SNOOZE.
        loadTime("set_d2_0659", 2, 6, 59);
        doTick("trigger_c");
        applyStimulus("snooze_c", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("disable", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("disable_state", int'(state), 0);

        // Random traffic.
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 1) == 1) ? 1 : 0;
            st = ($urandom_range(0, 19) == 0) ? 1 : 0;
            sa = ($urandom_range(0, 29) == 0) ? 1 : 0;
            sz = ($urandom_range(0, 9) == 0) ? 1 : 0;
            sp = ($urandom_range(0, 24) == 0) ? 1 : 0;
            if ($urandom_range(0, 39) == 0) en = 1 - en;
            d = $urandom_range(0, 7);
            h = $urandom_range(0, 25);
            m = $urandom_range(0, 63);
            if (!st && $urandom_range(0, 14) == 0) begin
                nt = (mWeek + 1) % WEEK_MIN;
                sa = 1; h = (nt % 1440) / 60; m = nt % 60;
            end
            applyStimulus("random", tk, st, sa, d, h, m, en, sz, sp);
        end

        // Asynchronous reset while ringing.
        applyStimulus("alarm0700b", 0, 0, 1, 0, 7, 0, 1, 0, 0);
        loadTime("set_0659d", 0, 6, 59);
        doTick("trigger_d");
        doTick("ring_d");
        @(negedge clk);
        #2;
        rst_n = 0;
        modelReset();
        #1;
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1;
        doTick("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
